// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the pipeline stages.
// Holds the datapath width, the funct3 encodings used by loads and stores,
// the access-size classification and the MEM stage wait-state FSM states.
package rv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings for load/store instructions
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  // Access size lives in funct3[1:0]; funct3[2] only selects zero extension.
  // Unused size code 2'b11 is treated as a word access.
  function automatic access_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment for data memory accesses (purely combinational).
// Ports:
//   funct3      in   access size / sign selection
//   lane        in   byte offset within the addressed word
//   store_data  in   register value to be stored
//   read_word   in   full 32-bit word read from memory
//   byte_en     out  per-byte write enables (all zero when misaligned)
//   store_word  out  store data replicated onto the selected lane(s)
//   load_data   out  selected lane, sign- or zero-extended (0 when misaligned)
//   misalign    out  halfword on odd address or word not on a 4-byte boundary
module mem_lane_align
  import rv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] read_word,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] store_word,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);

  access_size_e    size;
  logic [XLEN-1:0] shifted;

  // Stores replicate the low byte/half across the word so the byte enables
  // alone pick the destination lane; loads shift the lane down to bit 0.
  always_comb begin
    size       = size_of(funct3);
    shifted    = read_word >> {lane, 3'b000};
    misalign   = 1'b0;
    byte_en    = 4'b0000;
    store_word = store_data;
    load_data  = '0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{store_data[7:0]}};
        load_data  = funct3[2] ? {24'h0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign   = lane[0];
        byte_en    = lane[0] ? 4'b0000 : (lane[1] ? 4'b1100 : 4'b0011);
        store_word = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'h0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misalign   = |lane;
        byte_en    = (|lane) ? 4'b0000 : 4'b1111;
        store_word = store_data;
        load_data  = read_word;
      end
    endcase
    if (misalign) begin
      load_data = '0;
    end
  end

endmodule

// File: rtl/mem_stage_param.sv
// MEM stage of the 5-stage RV32I pipeline.
// Data memory with byte/half/word access, optional wait states that stall
// the upstream pipeline, branch/jump resolution and the MEM/WB register.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   Ctl_*_in, funct3_in, Rd_in, jal_in, jalr_in, Zero_in   EX/MEM control
//   Write_Data_in, ALUresult_in, PCimm_in, PC_in            EX/MEM data
//   PCSrc_out, PC_branch_out  redirect request and target for the PC mux
//   mem_stall_out             hold IF..EX/MEM this cycle
//   misalign_out              current access is misaligned
//   Ctl_*_out, jal_out, jalr_out, Rd_out, Read_Data_out,
//   ALUresult_out, PC_out     MEM/WB register
module mem_stage_param
  import rv_pkg::*;
#(
  parameter int              DEPTH       = 128,
  parameter int              WAIT_STATES = 0,
  parameter int              INIT_INDEX  = 22,
  parameter logic [XLEN-1:0] INIT_VALUE  = 32'd12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_Branch_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      Rd_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic            Zero_in,
  input  logic [XLEN-1:0] Write_Data_in,
  input  logic [XLEN-1:0] ALUresult_in,
  input  logic [XLEN-1:0] PCimm_in,
  input  logic [XLEN-1:0] PC_in,
  output logic            PCSrc_out,
  output logic [XLEN-1:0] PC_branch_out,
  output logic            mem_stall_out,
  output logic            misalign_out,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic            jal_out,
  output logic            jalr_out,
  output logic [4:0]      Rd_out,
  output logic [XLEN-1:0] Read_Data_out,
  output logic [XLEN-1:0] ALUresult_out,
  output logic [XLEN-1:0] PC_out
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] INIT_IDX  = AW'(INIT_INDEX);
  localparam bit            HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0]    WAIT_LOAD = 4'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic            unused_upper_addr;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] store_word;
  logic [XLEN-1:0] load_data;
  logic            misalign;
  logic            access;
  logic            aligned_access;
  logic            commit;
  logic [XLEN-1:0] read_data;

  mem_state_e      state;
  logic [3:0]      cnt;

  // Address bits above the memory size wrap silently.
  assign word_idx          = ALUresult_in[AW+1:2];
  assign lane              = ALUresult_in[1:0];
  assign unused_upper_addr = ^ALUresult_in[XLEN-1:AW+2];

  mem_lane_align u_align (
    .funct3     (funct3_in),
    .lane       (lane),
    .store_data (Write_Data_in),
    .read_word  (mem[word_idx]),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  assign access         = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign aligned_access = access & ~misalign;
  assign misalign_out   = access & misalign;

  // Stall is raised in the first cycle of an aligned access and held until
  // the counter runs out; the cycle with stall low is the completion cycle.
  always_comb begin
    mem_stall_out = 1'b0;
    case (state)
      ST_IDLE: mem_stall_out = HAS_WAIT & aligned_access;
      ST_WAIT: mem_stall_out = (cnt != 4'd0);
      default: mem_stall_out = 1'b0;
    endcase
  end

  // Stores commit only in the completion cycle, so exactly once per access.
  assign commit = aligned_access & Ctl_MemWrite_in & ~mem_stall_out;

  // A simultaneous write wins; the read result is forced to zero.
  assign read_data = (Ctl_MemRead_in & ~Ctl_MemWrite_in & ~misalign) ? load_data : '0;

  assign PCSrc_out     = Ctl_Branch_in & (Zero_in | jal_in | jalr_in) & ~mem_stall_out;
  assign PC_branch_out = jalr_in ? ALUresult_in : PCimm_in;

  // Wait-state FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (HAS_WAIT && aligned_access) begin
            state <= ST_WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Data memory: cleared on reset except for the preloaded word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      mem[INIT_IDX] <= INIT_VALUE;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
        end
      end
    end
  end

  // MEM/WB register; a stalled cycle injects a bubble
  always_ff @(posedge clk) begin
    if (reset || mem_stall_out) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
      Rd_out           <= 5'd0;
      Read_Data_out    <= '0;
      ALUresult_out    <= '0;
      PC_out           <= '0;
    end else begin
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
      Ctl_RegWrite_out <= Ctl_RegWrite_in;
      jal_out          <= jal_in;
      jalr_out         <= jalr_in;
      Rd_out           <= Rd_in;
      Read_Data_out    <= read_data;
      ALUresult_out    <= ALUresult_in;
      PC_out           <= PC_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_param.sv
// Testbench for mem_stage_param: one instance without wait states and one
// with two wait states, checked against a byte-addressed memory model.
module tb_mem_stage_param;

  typedef struct packed {
    logic        memto;
    logic        regw;
    logic        memr;
    logic        memw;
    logic        br;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        jal;
    logic        jalr;
    logic        zero;
    logic [31:0] wd;
    logic [31:0] alu;
    logic [31:0] pcimm;
    logic [31:0] pc;
  } stim_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  use2;
  stim_t cur, in0, in2;
  int    checks = 0;
  int    errors = 0;

  logic [7:0] mdl [2][512];
  logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  logic        pcsrc0, stall0, mis0, memto0, regw0, jal0, jalr0;
  logic        pcsrc2, stall2, mis2, memto2, regw2, jal2, jalr2;
  logic [4:0]  rd0, rd2;
  logic [31:0] pcb0, rdata0, alu0, pc0, pcb2, rdata2, alu2, pc2;

  logic        pcsrc, stall, mis, memto, regw, jal_o, jalr_o;
  logic [4:0]  rd_o;
  logic [31:0] pcb, rdata, alu_o, pc_o;

  always #5 clk = ~clk;

  assign in0 = use2 ? '0 : cur;
  assign in2 = use2 ? cur : '0;

  assign pcsrc  = use2 ? pcsrc2 : pcsrc0;
  assign pcb    = use2 ? pcb2   : pcb0;
  assign stall  = use2 ? stall2 : stall0;
  assign mis    = use2 ? mis2   : mis0;
  assign memto  = use2 ? memto2 : memto0;
  assign regw   = use2 ? regw2  : regw0;
  assign jal_o  = use2 ? jal2   : jal0;
  assign jalr_o = use2 ? jalr2  : jalr0;
  assign rd_o   = use2 ? rd2    : rd0;
  assign rdata  = use2 ? rdata2 : rdata0;
  assign alu_o  = use2 ? alu2   : alu0;
  assign pc_o   = use2 ? pc2    : pc0;

  mem_stage_param #(.DEPTH(128), .WAIT_STATES(0), .INIT_INDEX(22), .INIT_VALUE(32'd12)) dut0 (
    .clk(clk), .reset(reset),
    .Ctl_MemtoReg_in(in0.memto), .Ctl_RegWrite_in(in0.regw), .Ctl_MemRead_in(in0.memr),
    .Ctl_MemWrite_in(in0.memw), .Ctl_Branch_in(in0.br), .funct3_in(in0.f3), .Rd_in(in0.rd),
    .jal_in(in0.jal), .jalr_in(in0.jalr), .Zero_in(in0.zero), .Write_Data_in(in0.wd),
    .ALUresult_in(in0.alu), .PCimm_in(in0.pcimm), .PC_in(in0.pc),
    .PCSrc_out(pcsrc0), .PC_branch_out(pcb0), .mem_stall_out(stall0), .misalign_out(mis0),
    .Ctl_MemtoReg_out(memto0), .Ctl_RegWrite_out(regw0), .jal_out(jal0), .jalr_out(jalr0),
    .Rd_out(rd0), .Read_Data_out(rdata0), .ALUresult_out(alu0), .PC_out(pc0)
  );

  mem_stage_param #(.DEPTH(128), .WAIT_STATES(2), .INIT_INDEX(22), .INIT_VALUE(32'd12)) dut2 (
    .clk(clk), .reset(reset),
    .Ctl_MemtoReg_in(in2.memto), .Ctl_RegWrite_in(in2.regw), .Ctl_MemRead_in(in2.memr),
    .Ctl_MemWrite_in(in2.memw), .Ctl_Branch_in(in2.br), .funct3_in(in2.f3), .Rd_in(in2.rd),
    .jal_in(in2.jal), .jalr_in(in2.jalr), .Zero_in(in2.zero), .Write_Data_in(in2.wd),
    .ALUresult_in(in2.alu), .PCimm_in(in2.pcimm), .PC_in(in2.pc),
    .PCSrc_out(pcsrc2), .PC_branch_out(pcb2), .mem_stall_out(stall2), .misalign_out(mis2),
    .Ctl_MemtoReg_out(memto2), .Ctl_RegWrite_out(regw2), .jal_out(jal2), .jalr_out(jalr2),
    .Rd_out(rd2), .Read_Data_out(rdata2), .ALUresult_out(alu2), .PC_out(pc2)
  );

  // Reference memory: 512 bytes, little endian, word 22 preloaded with 12
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 512; i++) mdl[m][i] = 8'h00;
      mdl[m][88] = 8'd12;
    end
  endtask

  function automatic logic model_misal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int m, input logic [2:0] f3, input logic [31:0] a);
    int b;
    b = int'(a % 32'd512);
    case (f3)
      3'b000:  return {{24{mdl[m][b][7]}}, mdl[m][b]};
      3'b100:  return {24'h0, mdl[m][b]};
      3'b001:  return {{16{mdl[m][b+1][7]}}, mdl[m][b+1], mdl[m][b]};
      3'b101:  return {16'h0, mdl[m][b+1], mdl[m][b]};
      default: return {mdl[m][b+3], mdl[m][b+2], mdl[m][b+1], mdl[m][b]};
    endcase
  endfunction

  task automatic model_store(input int m, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b, n;
    b = int'(a % 32'd512);
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int i = 0; i < n; i++) mdl[m][b+i] = d[8*i +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cur   = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_mem(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
    cur       = '0;
    cur.memr  = rd_en;
    cur.memw  = wr_en;
    cur.f3    = f3;
    cur.alu   = addr;
    cur.wd    = data;
    cur.regw  = rd_en;
    cur.memto = rd_en;
    cur.rd    = 5'd5;
  endtask

  task automatic test_reset();
    use2 = 1'b0;
    do_reset();
    #1;
    checks++;
    if ({pcsrc, stall, memto, regw, jal_o, jalr_o, rd_o, rdata, alu_o, pc_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rd=%h rdata=%h alu=%h pc=%h regw=%b stall=%b expected all 0",
               rd_o, rdata, alu_o, pc_o, regw, stall);
    end
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b010, 32'd88, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (rdata !== 32'd12) begin
      errors++;
      $display("[TB] FAIL init_word: got %h expected %h", rdata, 32'd12);
    end
  endtask

  task automatic test_load_store();
    logic        wr  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3  [4] = '{3'b000, 3'b000, 3'b100, 3'b010};
    logic [31:0] adr [4] = '{32'h41, 32'h41, 32'h41, 32'h40};
    logic [31:0] exp [4] = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'h00008000};
    use2 = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_mem(~wr[i], wr[i], f3[i], adr[i], 32'h80);
      @(posedge clk); #1;
      checks++;
      if (rdata !== exp[i]) begin
        errors++;
        $display("[TB] FAIL load_store[%0d]: got %h expected %h", i, rdata, exp[i]);
      end
    end
  endtask

  task automatic test_misalign();
    use2 = 1'b0;
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b001, 32'h43, 32'h0);
    #1;
    checks++;
    if (mis !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misalign_lh: got mis=%b stall=%b expected 1 0", mis, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL misalign_lh_data: got %h expected 0", rdata);
    end
    @(negedge clk);
    set_mem(1'b0, 1'b1, 3'b010, 32'h42, 32'hFFFFFFFF);
    #1;
    checks++;
    if (mis !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misalign_sw: got %b expected 1", mis);
    end
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (rdata !== 32'h00008000) begin
      errors++;
      $display("[TB] FAIL misalign_sw_nowrite: got %h expected %h", rdata, 32'h00008000);
    end
  endtask

  task automatic test_branch();
    logic [31:0] tgt;
    logic        src;
    use2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cur       = '0;
      cur.br    = (i == 0 || i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      cur.zero  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cur.jalr  = (i == 1) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cur.jal   = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      cur.alu   = (i == 1) ? 32'h200 : $urandom;
      cur.pcimm = (i == 0) ? 32'h100 : $urandom;
      cur.pc    = $urandom;
      cur.rd    = 5'($urandom);
      tgt = cur.jalr ? cur.alu : cur.pcimm;
      src = cur.br && (cur.zero || cur.jal || cur.jalr);
      #1;
      checks++;
      if (pcsrc !== src || pcb !== tgt) begin
        errors++;
        $display("[TB] FAIL branch[%0d]: got src=%b tgt=%h expected src=%b tgt=%h", i, pcsrc, pcb, src, tgt);
      end
      @(posedge clk); #1;
      checks++;
      if (jal_o !== cur.jal || jalr_o !== cur.jalr || pc_o !== cur.pc || rd_o !== cur.rd) begin
        errors++;
        $display("[TB] FAIL branch_wb[%0d]: got jal=%b jalr=%b pc=%h rd=%h expected %b %b %h %h",
                 i, jal_o, jalr_o, pc_o, rd_o, cur.jal, cur.jalr, cur.pc, cur.rd);
      end
    end
  endtask

  task automatic test_random_nowait();
    int          kind;
    logic        mis_e;
    logic [31:0] exp;
    use2 = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      kind      = $urandom_range(0, 9);
      cur       = '0;
      cur.memr  = (kind <= 3) || (kind == 7);
      cur.memw  = (kind >= 4) && (kind <= 7);
      cur.f3    = cur.memw ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      cur.alu   = ($urandom & 32'hFFFFFE00) | 32'($urandom_range(0, 63));
      cur.wd    = $urandom;
      cur.rd    = 5'($urandom);
      cur.regw  = 1'($urandom);
      cur.memto = 1'($urandom);
      cur.pc    = $urandom;
      mis_e = (cur.memr || cur.memw) && model_misal(cur.f3, cur.alu);
      exp   = (cur.memr && !cur.memw && !mis_e) ? model_load(0, cur.f3, cur.alu) : 32'h0;
      #1;
      checks++;
      if (mis !== mis_e || stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_mis[%0d]: got mis=%b stall=%b expected %b 0", i, mis, stall, mis_e);
      end
      @(posedge clk); #1;
      checks++;
      if (rdata !== exp || rd_o !== cur.rd || regw !== cur.regw || memto !== cur.memto ||
          alu_o !== cur.alu || pc_o !== cur.pc) begin
        errors++;
        $display("[TB] FAIL rand_wb[%0d]: got rdata=%h rd=%h alu=%h expected %h %h %h",
                 i, rdata, rd_o, alu_o, exp, cur.rd, cur.alu);
      end
      if (cur.memw && !mis_e) model_store(0, cur.f3, cur.alu, cur.wd);
    end
  endtask

  task automatic test_wait_states();
    logic        src_e;
    logic        st_e;
    logic [31:0] exp;
    int          n, exp_n, kind;
    logic        mis_e;
    use2 = 1'b1;
    do_reset();
    // LW word 22 with a taken branch riding along; then SW and LW of word 17
    for (int op = 0; op < 3; op++) begin
      @(negedge clk);
      if (op == 0) set_mem(1'b1, 1'b0, 3'b010, 32'd88, 32'h0);
      else         set_mem(op == 2, op == 1, 3'b010, 32'h44, 32'hA5A5A5A5);
      cur.br    = (op == 0);
      cur.zero  = (op == 0);
      cur.pcimm = 32'h100;
      exp = (op == 0) ? 32'd12 : (op == 2) ? 32'hA5A5A5A5 : 32'h0;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        st_e  = (c < 2);
        src_e = (op == 0) && (c == 2);
        checks++;
        if (stall !== st_e || pcsrc !== src_e) begin
          errors++;
          $display("[TB] FAIL ws_stall[%0d.%0d]: got stall=%b pcsrc=%b expected %b %b",
                   op, c, stall, pcsrc, st_e, src_e);
        end
        @(posedge clk); #1;
        checks++;
        if (c < 2 && (regw !== 1'b0 || rdata !== 32'h0 || rd_o !== 5'd0)) begin
          errors++;
          $display("[TB] FAIL ws_bubble[%0d.%0d]: got regw=%b rdata=%h expected 0 0", op, c, regw, rdata);
        end else if (c == 2 && (rdata !== exp || regw !== cur.regw)) begin
          errors++;
          $display("[TB] FAIL ws_data[%0d]: got %h expected %h", op, rdata, exp);
        end
      end
    end
    model_store(1, 3'b010, 32'h44, 32'hA5A5A5A5);
    // Random traffic with bounded stall waits
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      kind     = $urandom_range(0, 9);
      cur      = '0;
      cur.memr = (kind <= 3) || (kind == 7);
      cur.memw = (kind >= 4) && (kind <= 7);
      cur.f3   = cur.memw ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      cur.alu  = ($urandom & 32'hFFFFFE00) | 32'($urandom_range(64, 95));
      cur.wd   = $urandom;
      cur.rd   = 5'($urandom);
      cur.regw = 1'b1;
      mis_e = (cur.memr || cur.memw) && model_misal(cur.f3, cur.alu);
      exp   = (cur.memr && !cur.memw && !mis_e) ? model_load(1, cur.f3, cur.alu) : 32'h0;
      exp_n = ((cur.memr || cur.memw) && !mis_e) ? 2 : 0;
      #1;
      n = 0;
      while (stall === 1'b1 && n < 10) begin
        @(posedge clk); #1;
        checks++;
        if (regw !== 1'b0 || rdata !== 32'h0) begin
          errors++;
          $display("[TB] FAIL ws_rand_bubble[%0d]: got regw=%b rdata=%h expected 0 0", i, regw, rdata);
        end
        n++;
        @(negedge clk); #1;
      end
      checks++;
      if (n != exp_n) begin
        errors++;
        $display("[TB] FAIL ws_rand_cycles[%0d]: got %0d stall cycles expected %0d", i, n, exp_n);
      end
      @(posedge clk); #1;
      checks++;
      if (rdata !== exp || rd_o !== cur.rd) begin
        errors++;
        $display("[TB] FAIL ws_rand_data[%0d]: got %h expected %h", i, rdata, exp);
      end
      if (cur.memw && !mis_e) model_store(1, cur.f3, cur.alu, cur.wd);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    use2 = 1'b1;
    do_reset();
    @(negedge clk);
    set_mem(1'b0, 1'b1, 3'b010, 32'd88, 32'hDEADBEEF);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_wait_start: got stall=%b expected 1", stall);
    end
    @(negedge clk);
    reset = 1'b1;
    cur   = '0;
    @(posedge clk); #1;
    checks++;
    if (regw !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_wait_wb: got regw=%b rdata=%h expected 0 0", regw, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_wait_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    set_mem(1'b1, 1'b0, 3'b010, 32'd88, 32'h0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL rst_wait_reload_cycles: got %0d expected 2", n);
    end
    @(posedge clk); #1;
    checks++;
    if (rdata !== model_load(1, 3'b010, 32'd88)) begin
      errors++;
      $display("[TB] FAIL rst_wait_word: got %h expected %h", rdata, model_load(1, 3'b010, 32'd88));
    end
  endtask

  initial begin
    reset = 1'b1;
    use2  = 1'b0;
    cur   = '0;
    test_reset();
    test_load_store();
    test_misalign();
    test_branch();
    test_random_nowait();
    test_wait_states();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
